// File: rtl/paddle_ctrl_pkg.sv
// Shared types and screen geometry for the paddle motion engine.
package paddle_ctrl_pkg;

    localparam int X_POS_W       = 10;
    localparam int Y_POS_W       = 10;
    localparam int SCREEN_V_RES  = 480;
    localparam int SCREEN_BORDER = 10;
    localparam int PADDLE_HEIGHT = 50;
    localparam int PADDLE_WIDTH  = 10;
    localparam int PADDLE_CENTER = PADDLE_HEIGHT / 2;                            // 25
    localparam int V_CENTER      = (SCREEN_V_RES - PADDLE_HEIGHT) / 2;           // 215
    localparam int DOWN_LIMIT    = SCREEN_V_RES - SCREEN_BORDER - PADDLE_HEIGHT; // 420

    typedef struct packed {
        logic [X_POS_W-1:0] x_pos;
        logic [Y_POS_W-1:0] y_pos;
        logic [X_POS_W-1:0] right;
        logic [Y_POS_W-1:0] bottom;
    } sprite_t;

    // Encodings 0 and 3 both mean "hold still".
    typedef enum logic [1:0] {
        MODE_HOLD     = 2'd0,
        MODE_MANUAL   = 2'd1,
        MODE_AI       = 2'd2,
        MODE_HOLD_ALT = 2'd3
    } paddle_mode_e;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_UPDATE = 2'd1,
        ST_DONE   = 2'd2
    } paddle_state_e;

    // Build a full sprite from its top-left corner; right/bottom follow from the fixed paddle size.
    function automatic sprite_t make_sprite(input logic [X_POS_W-1:0] x, input logic [Y_POS_W-1:0] y);
        sprite_t s;
        s.x_pos  = x;
        s.y_pos  = y;
        s.right  = x + X_POS_W'(PADDLE_WIDTH);
        s.bottom = y + Y_POS_W'(PADDLE_HEIGHT);
        return s;
    endfunction

endpackage

// File: rtl/paddle_ctrl_if.sv
// Bundle of control inputs and sprite/status outputs between game logic and paddle_ctrl.
interface paddle_ctrl_if #(
    parameter int N_PADDLES = 2,
    parameter int STEP_W    = 4
) ();
    import paddle_ctrl_pkg::*;

    logic                          frame_tick_i;
    logic                          recenter_i;
    logic [N_PADDLES*2-1:0]        mode_i;
    logic [N_PADDLES*STEP_W-1:0]   step_i;
    logic [N_PADDLES-1:0]          up_i;
    logic [N_PADDLES-1:0]          down_i;
    logic [Y_POS_W-1:0]            ball_cy_i;
    sprite_t [N_PADDLES-1:0]       sprites_o;
    logic                          busy_o;
    logic                          done_o;
    logic                          overrun_o;

    modport master (
        output frame_tick_i, recenter_i, mode_i, step_i, up_i, down_i, ball_cy_i,
        input  sprites_o, busy_o, done_o, overrun_o
    );

    modport slave (
        input  frame_tick_i, recenter_i, mode_i, step_i, up_i, down_i, ball_cy_i,
        output sprites_o, busy_o, done_o, overrun_o
    );

endinterface

// File: rtl/paddle_ctrl_step.sv
// Shared combinational datapath: computes one paddle's next clamped y position.
module paddle_ctrl_step
    import paddle_ctrl_pkg::*;
#(
    parameter int STEP_W   = 4,
    parameter int DEADBAND = 2
) (
    input  logic [Y_POS_W-1:0] y_i,
    input  paddle_mode_e       mode_i,
    input  logic [STEP_W-1:0]  step_i,
    input  logic               up_i,
    input  logic               down_i,
    input  logic [Y_POS_W-1:0] ball_cy_i,
    output logic [Y_POS_W-1:0] y_o
);
    // Two guard bits so the signed sum can go below zero or past the screen without wrapping.
    localparam int SW = Y_POS_W + 2;
    localparam logic signed [SW-1:0] BORDER_S   = SW'(SCREEN_BORDER);
    localparam logic signed [SW-1:0] LIMIT_S    = SW'(DOWN_LIMIT);
    localparam logic signed [SW-1:0] DEADBAND_S = SW'(DEADBAND);
    localparam logic signed [SW-1:0] CENTER_S   = SW'(PADDLE_CENTER);

    logic signed [SW-1:0] y_s, step_s, diff_s, mag_s, lim_s, move_s, next_s;

    // Select the per-mode displacement, then add and clamp to the playfield.
    always_comb begin
        y_s    = SW'(y_i);
        step_s = SW'(step_i);
        diff_s = SW'(ball_cy_i) - CENTER_S - y_s;
        mag_s  = (diff_s < 0) ? -diff_s : diff_s;
        lim_s  = (step_s < mag_s) ? step_s : mag_s;
        move_s = '0;
        case (mode_i)
            MODE_MANUAL: begin
                if (up_i && !down_i) begin
                    move_s = -step_s;
                end else if (down_i && !up_i) begin
                    move_s = step_s;
                end else begin
                    move_s = '0;
                end
            end
            MODE_AI: begin
                if (mag_s <= DEADBAND_S) begin
                    move_s = '0;
                end else if (diff_s < 0) begin
                    move_s = -lim_s;
                end else begin
                    move_s = lim_s;
                end
            end
            default: move_s = '0;
        endcase
        next_s = y_s + move_s;
        if (next_s < BORDER_S) begin
            next_s = BORDER_S;
        end else if (next_s > LIMIT_S) begin
            next_s = LIMIT_S;
        end else begin
            next_s = next_s;
        end
        y_o = next_s[Y_POS_W-1:0];
    end

endmodule

// File: rtl/paddle_ctrl.sv
// Paddle motion engine: per frame tick, walks all paddles through one shared step datapath.
module paddle_ctrl
    import paddle_ctrl_pkg::*;
#(
    parameter int N_PADDLES = 2,
    parameter int STEP_W    = 4,
    parameter int DEADBAND  = 2,
    parameter logic [N_PADDLES-1:0][X_POS_W-1:0] PADDLE_X = {10'd610, 10'd30}
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    paddle_ctrl_if.slave  bus
);
    localparam int IDX_W = (N_PADDLES > 1) ? $clog2(N_PADDLES) : 1;

    paddle_state_e                  state_q;
    logic [IDX_W-1:0]               idx_q;
    logic [N_PADDLES-1:0][1:0]      mode_q;
    logic [N_PADDLES-1:0][STEP_W-1:0] step_q;
    logic [N_PADDLES-1:0]           up_q;
    logic [N_PADDLES-1:0]           down_q;
    logic [Y_POS_W-1:0]             ball_q;
    sprite_t [N_PADDLES-1:0]        sprites_q;
    logic                           busy_q;
    logic                           done_q;
    logic                           overrun_q;
    logic [Y_POS_W-1:0]             y_d;

    paddle_ctrl_step #(
        .STEP_W   (STEP_W),
        .DEADBAND (DEADBAND)
    ) u_step (
        .y_i       (sprites_q[idx_q].y_pos),
        .mode_i    (paddle_mode_e'(mode_q[idx_q])),
        .step_i    (step_q[idx_q]),
        .up_i      (up_q[idx_q]),
        .down_i    (down_q[idx_q]),
        .ball_cy_i (ball_q),
        .y_o       (y_d)
    );

    // Frame sequencer: snapshot on tick, update one paddle per cycle, pulse done; recenter overrides all.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q   <= ST_IDLE;
            idx_q     <= '0;
            mode_q    <= '0;
            step_q    <= '0;
            up_q      <= '0;
            down_q    <= '0;
            ball_q    <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            overrun_q <= 1'b0;
            for (int i = 0; i < N_PADDLES; i++) begin
                sprites_q[i] <= make_sprite(PADDLE_X[i], Y_POS_W'(V_CENTER));
            end
        end else if (bus.recenter_i) begin
            // A tick in the same cycle is simply dropped and does not count as an overrun.
            state_q <= ST_IDLE;
            idx_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            for (int i = 0; i < N_PADDLES; i++) begin
                sprites_q[i] <= make_sprite(PADDLE_X[i], Y_POS_W'(V_CENTER));
            end
        end else begin
            case (state_q)
                ST_IDLE: begin
                    done_q <= 1'b0;
                    if (bus.frame_tick_i) begin
                        mode_q  <= bus.mode_i;
                        step_q  <= bus.step_i;
                        up_q    <= bus.up_i;
                        down_q  <= bus.down_i;
                        ball_q  <= bus.ball_cy_i;
                        idx_q   <= '0;
                        busy_q  <= 1'b1;
                        state_q <= ST_UPDATE;
                    end
                end
                ST_UPDATE: begin
                    sprites_q[idx_q] <= make_sprite(PADDLE_X[idx_q], y_d);
                    if (bus.frame_tick_i) begin
                        overrun_q <= 1'b1;
                    end
                    if (idx_q == IDX_W'(N_PADDLES - 1)) begin
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        state_q <= ST_DONE;
                    end else begin
                        idx_q <= idx_q + IDX_W'(1);
                    end
                end
                ST_DONE: begin
                    done_q  <= 1'b0;
                    state_q <= ST_IDLE;
                    if (bus.frame_tick_i) begin
                        overrun_q <= 1'b1;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.sprites_o = sprites_q;
    assign bus.busy_o    = busy_q;
    assign bus.done_o    = done_q;
    assign bus.overrun_o = overrun_q;

endmodule

// File: tb/tb_paddle_ctrl.sv
// Self-checking bench for paddle_ctrl: directed scenarios plus randomized frames against a reference model.
module tb_paddle_ctrl;
    import paddle_ctrl_pkg::*;

    localparam int N  = 2;
    localparam int SW = 4;
    localparam int DB = 2;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    paddle_ctrl_if #(.N_PADDLES(N), .STEP_W(SW)) bus();

    paddle_ctrl #(
        .N_PADDLES (N),
        .STEP_W    (SW),
        .DEADBAND  (DB),
        .PADDLE_X  ({10'd610, 10'd30})
    ) dut (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .bus    (bus)
    );

    int errors = 0;
    int checks = 0;
    int ref_y[N];
    int px[N] = '{30, 610};

    // Reference: next y from the written motion rules, plain integer arithmetic.
    function automatic int model_next(int y, int m, int s, bit u, bit d, int b);
        int n, t;
        n = y;
        if (m == 1) begin
            if (u && !d) n = y - s;
            else if (d && !u) n = y + s;
        end else if (m == 2) begin
            t = (b - 25) - y;
            if (t > DB) n = y + ((s < t) ? s : t);
            else if (t < -DB) n = y - ((s < -t) ? s : -t);
        end
        if (n < 10) n = 10;
        if (n > 420) n = 420;
        return n;
    endfunction

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic quiet();
        bus.frame_tick_i = 1'b0;
        bus.recenter_i   = 1'b0;
        bus.mode_i       = '0;
        bus.step_i       = '0;
        bus.up_i         = '0;
        bus.down_i       = '0;
        bus.ball_cy_i    = '0;
    endtask

    task automatic do_reset();
        quiet();
        rst_n = 1'b0;
        cycle();
        cycle();
        rst_n = 1'b1;
        for (int i = 0; i < N; i++) ref_y[i] = 215;
    endtask

    task automatic do_recenter();
        bus.recenter_i = 1'b1;
        cycle();
        bus.recenter_i = 1'b0;
        for (int i = 0; i < N; i++) ref_y[i] = 215;
    endtask

    // One full frame: apply inputs, pulse tick, scramble inputs, wait (bounded) for done, return to idle.
    task automatic run_frame(input logic [2*N-1:0] m, input logic [N*SW-1:0] s,
                             input logic [N-1:0] u, input logic [N-1:0] d,
                             input logic [9:0] b, output int lat);
        for (int i = 0; i < N; i++)
            ref_y[i] = model_next(ref_y[i], int'(m[2*i +: 2]), int'(s[i*SW +: SW]), u[i], d[i], int'(b));
        bus.mode_i = m; bus.step_i = s; bus.up_i = u; bus.down_i = d; bus.ball_cy_i = b;
        bus.frame_tick_i = 1'b1;
        cycle();
        bus.frame_tick_i = 1'b0;
        bus.mode_i    = (2*N)'($urandom);
        bus.step_i    = (N*SW)'($urandom);
        bus.up_i      = N'($urandom);
        bus.down_i    = N'($urandom);
        bus.ball_cy_i = 10'($urandom);
        lat = 1;
        while (bus.done_o !== 1'b1 && lat < 20) begin
            cycle();
            lat++;
        end
        cycle();
    endtask

    task automatic move_to(input int p, input int target);
        logic [2*N-1:0] m;
        logic [N*SW-1:0] s;
        logic [N-1:0] u, d;
        int diff, st, lat, guard;
        guard = 0;
        while (ref_y[p] != target && guard < 100) begin
            diff = target - ref_y[p];
            st = (diff < 0) ? -diff : diff;
            if (st > 15) st = 15;
            m = '0; s = '0; u = '0; d = '0;
            m[2*p +: 2] = 2'd1;
            s[p*SW +: SW] = SW'(st);
            if (diff < 0) u[p] = 1'b1; else d[p] = 1'b1;
            run_frame(m, s, u, d, 10'd0, lat);
            guard++;
        end
    endtask

    task automatic test_reset();
        do_reset();
        for (int i = 0; i < N; i++) begin
            checks++;
            if (bus.sprites_o[i].y_pos !== 10'd215 || bus.sprites_o[i].x_pos !== 10'(px[i]) ||
                bus.sprites_o[i].right !== 10'(px[i] + 10) || bus.sprites_o[i].bottom !== 10'd265) begin
                errors++;
                $display("FAIL reset_sprite%0d: got x=%0d y=%0d r=%0d b=%0d expected x=%0d y=215 r=%0d b=265", i,
                         bus.sprites_o[i].x_pos, bus.sprites_o[i].y_pos, bus.sprites_o[i].right,
                         bus.sprites_o[i].bottom, px[i], px[i] + 10);
            end
        end
        checks++;
        if ({bus.busy_o, bus.done_o, bus.overrun_o} !== 3'b000) begin
            errors++;
            $display("FAIL reset_flags: got %b expected 000", {bus.busy_o, bus.done_o, bus.overrun_o});
        end
    endtask

    task automatic test_manual();
        int lat;
        run_frame(4'b0001, 8'h04, 2'b01, 2'b00, 10'd0, lat);
        checks++;
        if (lat !== 3) begin errors++; $display("FAIL manual_latency: got %0d expected 3", lat); end
        checks++;
        if (bus.sprites_o[0].y_pos !== 10'd211 || bus.sprites_o[0].bottom !== 10'd261) begin
            errors++;
            $display("FAIL manual_up: got y=%0d b=%0d expected y=211 b=261", bus.sprites_o[0].y_pos, bus.sprites_o[0].bottom);
        end
        move_to(1, 418);
        run_frame(4'b0100, 8'h40, 2'b00, 2'b10, 10'd0, lat);
        checks++;
        if (bus.sprites_o[1].y_pos !== 10'd420 || bus.sprites_o[1].bottom !== 10'd470) begin
            errors++;
            $display("FAIL manual_clamp_low: got y=%0d b=%0d expected y=420 b=470", bus.sprites_o[1].y_pos, bus.sprites_o[1].bottom);
        end
        move_to(1, 12);
        run_frame(4'b0100, 8'h40, 2'b10, 2'b00, 10'd0, lat);
        checks++;
        if (bus.sprites_o[1].y_pos !== 10'd10) begin
            errors++; $display("FAIL manual_clamp_top: got %0d expected 10", bus.sprites_o[1].y_pos);
        end
        run_frame(4'b0100, 8'h40, 2'b10, 2'b10, 10'd0, lat);
        checks++;
        if (bus.sprites_o[1].y_pos !== 10'd10 || bus.sprites_o[0].y_pos !== 10'd211) begin
            errors++;
            $display("FAIL manual_both: got y1=%0d y0=%0d expected y1=10 y0=211", bus.sprites_o[1].y_pos, bus.sprites_o[0].y_pos);
        end
    endtask

    task automatic test_ai();
        int lat;
        logic [9:0] balls[3] = '{10'd300, 10'd241, 10'd243};
        logic [9:0] exp_y[3] = '{10'd223, 10'd215, 10'd218};
        for (int k = 0; k < 3; k++) begin
            do_recenter();
            run_frame(4'b0010, 8'h08, 2'b00, 2'b00, balls[k], lat);
            checks++;
            if (bus.sprites_o[0].y_pos !== exp_y[k]) begin
                errors++;
                $display("FAIL ai_ball%0d: got %0d expected %0d", balls[k], bus.sprites_o[0].y_pos, exp_y[k]);
            end
        end
    endtask

    task automatic test_overrun();
        int dones;
        ref_y[0] = model_next(ref_y[0], 1, 1, 1'b0, 1'b1, 0);
        ref_y[1] = model_next(ref_y[1], 1, 1, 1'b1, 1'b0, 0);
        bus.mode_i = 4'b0101; bus.step_i = 8'h11; bus.up_i = 2'b10; bus.down_i = 2'b01;
        bus.frame_tick_i = 1'b1;
        cycle();
        bus.mode_i = 4'b0000;
        cycle();
        bus.frame_tick_i = 1'b0;
        dones = 0;
        for (int c = 0; c < 8; c++) begin
            if (bus.done_o === 1'b1) dones++;
            cycle();
        end
        checks++;
        if (dones !== 1) begin errors++; $display("FAIL overrun_done_count: got %0d expected 1", dones); end
        checks++;
        if (bus.overrun_o !== 1'b1) begin errors++; $display("FAIL overrun_flag: got %b expected 1", bus.overrun_o); end
        checks++;
        if (bus.sprites_o[0].y_pos !== 10'(ref_y[0]) || bus.sprites_o[1].y_pos !== 10'(ref_y[1])) begin
            errors++;
            $display("FAIL overrun_positions: got %0d/%0d expected %0d/%0d", bus.sprites_o[0].y_pos,
                     bus.sprites_o[1].y_pos, ref_y[0], ref_y[1]);
        end
    endtask

    task automatic test_reset_mid();
        int dones;
        bus.mode_i = 4'b0101; bus.step_i = 8'h55; bus.up_i = 2'b11; bus.down_i = 2'b00;
        bus.frame_tick_i = 1'b1;
        cycle();
        bus.frame_tick_i = 1'b0;
        rst_n = 1'b0;
        cycle();
        rst_n = 1'b1;
        for (int i = 0; i < N; i++) ref_y[i] = 215;
        checks++;
        if ({bus.busy_o, bus.done_o, bus.overrun_o} !== 3'b000 ||
            bus.sprites_o[0].y_pos !== 10'd215 || bus.sprites_o[1].y_pos !== 10'd215) begin
            errors++;
            $display("FAIL reset_mid: got flags=%b y=%0d/%0d expected 000 215/215",
                     {bus.busy_o, bus.done_o, bus.overrun_o}, bus.sprites_o[0].y_pos, bus.sprites_o[1].y_pos);
        end
        dones = 0;
        for (int c = 0; c < 5; c++) begin
            if (bus.done_o === 1'b1) dones++;
            cycle();
        end
        checks++;
        if (dones !== 0) begin errors++; $display("FAIL reset_mid_done: got %0d expected 0", dones); end
    endtask

    task automatic test_recenter();
        int dones;
        move_to(0, 300);
        move_to(1, 100);
        bus.mode_i = 4'b0101; bus.step_i = 8'h44; bus.up_i = 2'b11; bus.down_i = 2'b00;
        bus.frame_tick_i = 1'b1;
        cycle();
        bus.frame_tick_i = 1'b0;
        do_recenter();
        checks++;
        if (bus.busy_o !== 1'b0 || bus.sprites_o[0].y_pos !== 10'd215 || bus.sprites_o[1].y_pos !== 10'd215) begin
            errors++;
            $display("FAIL recenter_mid: got busy=%b y=%0d/%0d expected 0 215/215",
                     bus.busy_o, bus.sprites_o[0].y_pos, bus.sprites_o[1].y_pos);
        end
        dones = 0;
        for (int c = 0; c < 5; c++) begin
            if (bus.done_o === 1'b1) dones++;
            cycle();
        end
        checks++;
        if (dones !== 0) begin errors++; $display("FAIL recenter_done: got %0d expected 0", dones); end
        // Recenter together with tick, once from IDLE and once from inside UPDATE.
        bus.frame_tick_i = 1'b1;
        do_recenter();
        bus.frame_tick_i = 1'b0;
        checks++;
        if (bus.busy_o !== 1'b0 || bus.overrun_o !== 1'b0) begin
            errors++; $display("FAIL recenter_tick_idle: got busy=%b ovr=%b expected 0 0", bus.busy_o, bus.overrun_o);
        end
        bus.frame_tick_i = 1'b1;
        cycle();
        do_recenter();
        bus.frame_tick_i = 1'b0;
        dones = 0;
        for (int c = 0; c < 5; c++) begin
            if (bus.done_o === 1'b1) dones++;
            cycle();
        end
        checks++;
        if (bus.overrun_o !== 1'b0 || dones !== 0) begin
            errors++; $display("FAIL recenter_tick_update: got ovr=%b dones=%0d expected 0 0", bus.overrun_o, dones);
        end
    endtask

    task automatic test_random();
        int lat;
        for (int f = 0; f < 3000; f++) begin
            if ($urandom_range(15, 0) == 0) begin
                do_recenter();
            end
            run_frame((2*N)'($urandom), (N*SW)'($urandom), N'($urandom), N'($urandom),
                      10'($urandom_range(520, 0)), lat);
            checks++;
            if (lat !== 3) begin errors++; $display("FAIL random_latency f%0d: got %0d expected 3", f, lat); end
            for (int i = 0; i < N; i++) begin
                checks++;
                if (bus.sprites_o[i].y_pos !== 10'(ref_y[i]) || bus.sprites_o[i].bottom !== 10'(ref_y[i] + 50)) begin
                    errors++;
                    $display("FAIL random_y f%0d p%0d: got y=%0d b=%0d expected y=%0d b=%0d", f, i,
                             bus.sprites_o[i].y_pos, bus.sprites_o[i].bottom, ref_y[i], ref_y[i] + 50);
                end
            end
        end
    endtask

    initial begin
        quiet();
        test_reset();
        test_manual();
        test_ai();
        test_overrun();
        test_reset_mid();
        test_recenter();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
